// File: rtl/bellek_erisim_denetleyici.sv
// Load/store sequencer between the RV32I memory stage and a word-wide data memory.
// One request at a time: load = read, SB/SH = read-modify-write, SW = single write.
module bellek_erisim_denetleyici #(
  parameter int BELLEK_KELIME = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        istek_gecerli,
  output logic        istek_hazir,
  input  logic        istek_yaz,
  input  logic [1:0]  istek_boyut,
  input  logic        istek_isaretsiz,
  input  logic [31:0] istek_adres,
  input  logic [31:0] istek_veri,
  output logic        yanit_gecerli,
  output logic [31:0] yanit_veri,
  output logic        yanit_hata,
  output logic        bellek_oku,
  output logic        bellek_yaz,
  output logic [31:0] bellek_adres,
  output logic [31:0] bellek_yaz_veri,
  input  logic [31:0] bellek_oku_veri
);

  localparam logic [29:0] KELIME_SINIRI = 30'(BELLEK_KELIME);

  typedef enum logic [1:0] {BOSTA, OKU, YAZ, YANIT} durum_t;

  durum_t      durum_q;
  logic        yaz_q;
  logic [1:0]  boyut_q;
  logic        isaretsiz_q;
  logic [1:0]  ofset_q;
  logic [31:0] veri_q;
  logic [31:0] adres_q;
  logic [31:0] yaz_veri_q;
  logic [31:0] yanit_veri_q;
  logic        hata_q;

  logic        hata_d;
  logic [31:0] birlesik_d;
  logic [31:0] cikan_d;
  logic [7:0]  bayt;
  logic [15:0] yarim;

  // Request classification happens on the raw inputs, in the accept cycle.
  always_comb begin
    hata_d = 1'b0;
    case (istek_boyut)
      2'b01:   hata_d = istek_adres[0];
      2'b10:   hata_d = (istek_adres[1:0] != 2'b00);
      2'b11:   hata_d = 1'b1;
      default: hata_d = 1'b0;
    endcase
    if (istek_adres[31:2] >= KELIME_SINIRI) begin
      hata_d = 1'b1;
    end
  end

  always_comb begin
    birlesik_d = bellek_oku_veri;
    if (boyut_q == 2'b00) begin
      case (ofset_q)
        2'd0:    birlesik_d[7:0]   = veri_q[7:0];
        2'd1:    birlesik_d[15:8]  = veri_q[7:0];
        2'd2:    birlesik_d[23:16] = veri_q[7:0];
        default: birlesik_d[31:24] = veri_q[7:0];
      endcase
    end else if (ofset_q[1]) begin
      birlesik_d[31:16] = veri_q[15:0];
    end else begin
      birlesik_d[15:0] = veri_q[15:0];
    end
  end

  always_comb begin
    case (ofset_q)
      2'd0:    bayt = bellek_oku_veri[7:0];
      2'd1:    bayt = bellek_oku_veri[15:8];
      2'd2:    bayt = bellek_oku_veri[23:16];
      default: bayt = bellek_oku_veri[31:24];
    endcase
    yarim = ofset_q[1] ? bellek_oku_veri[31:16] : bellek_oku_veri[15:0];
    case (boyut_q)
      2'b00:   cikan_d = {{24{~isaretsiz_q & bayt[7]}}, bayt};
      2'b01:   cikan_d = {{16{~isaretsiz_q & yarim[15]}}, yarim};
      default: cikan_d = bellek_oku_veri;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      durum_q      <= BOSTA;
      yaz_q        <= 1'b0;
      boyut_q      <= 2'b00;
      isaretsiz_q  <= 1'b0;
      ofset_q      <= 2'b00;
      veri_q       <= '0;
      adres_q      <= '0;
      yaz_veri_q   <= '0;
      yanit_veri_q <= '0;
      hata_q       <= 1'b0;
    end else begin
      case (durum_q)
        BOSTA: begin
          if (istek_gecerli) begin
            yaz_q        <= istek_yaz;
            boyut_q      <= istek_boyut;
            isaretsiz_q  <= istek_isaretsiz;
            ofset_q      <= istek_adres[1:0];
            veri_q       <= istek_veri;
            yanit_veri_q <= '0;
            hata_q       <= hata_d;
            if (hata_d) begin
              durum_q <= YANIT;
            end else begin
              adres_q <= {istek_adres[31:2], 2'b00};
              if (istek_yaz && istek_boyut == 2'b10) begin
                yaz_veri_q <= istek_veri;
                durum_q    <= YAZ;
              end else begin
                durum_q <= OKU;
              end
            end
          end
        end
        OKU: begin
          // Sub-word stores merge into the word just read; loads extract from it.
          if (yaz_q) begin
            yaz_veri_q <= birlesik_d;
            durum_q    <= YAZ;
          end else begin
            yanit_veri_q <= cikan_d;
            durum_q      <= YANIT;
          end
        end
        YAZ: begin
          durum_q <= YANIT;
        end
        default: begin
          yanit_veri_q <= '0;
          hata_q       <= 1'b0;
          durum_q      <= BOSTA;
        end
      endcase
    end
  end

  assign istek_hazir     = rst & (durum_q == BOSTA);
  assign bellek_oku      = (durum_q == OKU);
  assign bellek_yaz      = (durum_q == YAZ);
  assign bellek_adres    = adres_q;
  assign bellek_yaz_veri = yaz_veri_q;
  assign yanit_gecerli   = (durum_q == YANIT);
  assign yanit_veri      = yanit_veri_q;
  assign yanit_hata      = hata_q;

endmodule

// File: tb/tb_bellek_erisim_denetleyici.sv
// Scoreboard bench: a reference model predicts each response and memory image,
// a forked monitor pops predictions whenever the sequencer answers.
module tb_bellek_erisim_denetleyici;

  logic        clk;
  logic        rst;
  logic        istek_gecerli;
  logic        istek_hazir;
  logic        istek_yaz;
  logic [1:0]  istek_boyut;
  logic        istek_isaretsiz;
  logic [31:0] istek_adres;
  logic [31:0] istek_veri;
  logic        yanit_gecerli;
  logic [31:0] yanit_veri;
  logic        yanit_hata;
  logic        bellek_oku;
  logic        bellek_yaz;
  logic [31:0] bellek_adres;
  logic [31:0] bellek_yaz_veri;
  logic [31:0] bellek_oku_veri;

  bellek_erisim_denetleyici #(.BELLEK_KELIME(128)) dut (
    .clk(clk), .rst(rst),
    .istek_gecerli(istek_gecerli), .istek_hazir(istek_hazir),
    .istek_yaz(istek_yaz), .istek_boyut(istek_boyut),
    .istek_isaretsiz(istek_isaretsiz), .istek_adres(istek_adres),
    .istek_veri(istek_veri),
    .yanit_gecerli(yanit_gecerli), .yanit_veri(yanit_veri), .yanit_hata(yanit_hata),
    .bellek_oku(bellek_oku), .bellek_yaz(bellek_yaz), .bellek_adres(bellek_adres),
    .bellek_yaz_veri(bellek_yaz_veri), .bellek_oku_veri(bellek_oku_veri)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: samples controls on the falling edge.
  logic [31:0] mem [0:127];
  logic        pre_en;
  logic [6:0]  pre_idx;
  logic [31:0] pre_val;
  always @(negedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    if (bellek_yaz) mem[bellek_adres[8:2]] <= bellek_yaz_veri;
    if (bellek_oku) bellek_oku_veri <= mem[bellek_adres[8:2]];
  end

  typedef struct {
    logic [31:0] veri;
    logic        hata;
    int          lat;
    int          oku;
    int          yaz;
    int          acc;
    string       ad;
  } beklenen_t;

  beklenen_t   sb_q[$];
  logic [31:0] ref_mem [0:127];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(string ad, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", ad, got, want);
    end
  endtask

  // Reference model: architectural effect of one request.
  function automatic beklenen_t model(bit yaz, bit [1:0] boy, bit u, bit [31:0] adr,
                                      bit [31:0] veri);
    beklenen_t   e;
    int unsigned idx;
    int unsigned off;
    logic [31:0] w;
    logic [31:0] r;
    logic [31:0] mask;
    idx = adr >> 2;
    off = adr % 4;
    e.veri = 0; e.hata = 0; e.oku = 0; e.yaz = 0; e.lat = 0; e.acc = 0; e.ad = "";
    if (boy == 3 || (boy == 1 && adr % 2 != 0) || (boy == 2 && off != 0) || idx >= 128) begin
      e.hata = 1; e.lat = 1;
    end else if (!yaz) begin
      w = ref_mem[idx];
      e.lat = 2; e.oku = 1;
      if (boy == 0) begin
        r = (w >> (8 * off)) & 32'hFF;
        if (!u && r >= 128) r = r + 32'hFFFF_FF00;
      end else if (boy == 1) begin
        r = (w >> (16 * (off / 2))) & 32'hFFFF;
        if (!u && r >= 32768) r = r + 32'hFFFF_0000;
      end else begin
        r = w;
      end
      e.veri = r;
    end else if (boy == 2) begin
      ref_mem[idx] = veri;
      e.lat = 2; e.yaz = 1;
    end else begin
      w = ref_mem[idx];
      if (boy == 0) begin
        mask = 32'hFF << (8 * off);
        ref_mem[idx] = (w & ~mask) | ((veri & 32'hFF) << (8 * off));
      end else begin
        mask = 32'hFFFF << (16 * (off / 2));
        ref_mem[idx] = (w & ~mask) | ((veri & 32'hFFFF) << (16 * (off / 2)));
      end
      e.lat = 3; e.oku = 1; e.yaz = 1;
    end
    return e;
  endfunction

  task automatic preload(int idx, logic [31:0] val);
    pre_idx = 7'(idx); pre_val = val; pre_en = 1'b1;
    ref_mem[idx] = val;
    @(negedge clk); #1;
    pre_en = 1'b0;
  endtask

  // kes=1: pull reset one time unit after the accept edge.
  task automatic issue(bit yaz, bit [1:0] boy, bit u, bit [31:0] adr, bit [31:0] veri,
                       bit track, bit kes);
    beklenen_t e;
    int t = 0;
    while (!istek_hazir && t < 50) begin
      @(negedge clk); #1; t++;
    end
    chk("hazir_bekle", {31'b0, istek_hazir}, 32'd1);
    if (!istek_hazir) return;
    istek_gecerli = 1'b1; istek_yaz = yaz; istek_boyut = boy;
    istek_isaretsiz = u; istek_adres = adr; istek_veri = veri;
    if (track) begin
      e = model(yaz, boy, u, adr, veri);
      e.acc = cyc + 1;
      e.ad = $sformatf("%s b%0d u%0d a=%h", yaz ? "ST" : "LD", boy, u, adr);
      sb_q.push_back(e);
    end
    if (kes) begin
      @(posedge clk); #1;
      rst = 1'b0;
    end
    @(negedge clk); #1;
    istek_gecerli = 1'b0;
    istek_yaz = 1'($urandom()); istek_boyut = 2'($urandom());
    istek_adres = $urandom(); istek_veri = $urandom();
  endtask

  task automatic monitor();
    beklenen_t e;
    int oku_n = 0;
    int yaz_n = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        oku_n = 0; yaz_n = 0;
      end else begin
        if (bellek_oku && bellek_yaz) chk("oku_ve_yaz", 32'd1, 32'd0);
        if (bellek_oku) oku_n++;
        if (bellek_yaz) yaz_n++;
        if (yanit_gecerli) begin
          if (sb_q.size() == 0) begin
            chk("beklenmeyen_yanit", {31'b0, yanit_gecerli}, 32'd0);
          end else begin
            e = sb_q.pop_front();
            $display("yanit %s veri=%h hata=%0d gecikme=%0d", e.ad, yanit_veri, yanit_hata,
                     cyc - e.acc + 1);
            chk({e.ad, " veri"}, yanit_veri, e.veri);
            chk({e.ad, " hata"}, {31'b0, yanit_hata}, {31'b0, e.hata});
            chk({e.ad, " gecikme"}, cyc - e.acc + 1, e.lat);
            chk({e.ad, " oku_sayisi"}, oku_n, e.oku);
            chk({e.ad, " yaz_sayisi"}, yaz_n, e.yaz);
          end
          oku_n = 0; yaz_n = 0;
        end
      end
    end
  endtask

  task automatic bosalt();
    int t = 0;
    while ((sb_q.size() != 0 || !istek_hazir) && t < 100) begin
      @(negedge clk); #1; t++;
    end
    chk("bosalt_kuyruk", sb_q.size(), 0);
  endtask

  task automatic sifir_cikis(string ad);
    chk({ad, " hazir"}, {31'b0, istek_hazir}, 32'd0);
    chk({ad, " oku"}, {31'b0, bellek_oku}, 32'd0);
    chk({ad, " yaz"}, {31'b0, bellek_yaz}, 32'd0);
    chk({ad, " yanit"}, {31'b0, yanit_gecerli}, 32'd0);
    chk({ad, " adres"}, bellek_adres, 32'd0);
    chk({ad, " yaz_veri"}, bellek_yaz_veri, 32'd0);
    chk({ad, " yanit_veri"}, yanit_veri, 32'd0);
  endtask

  localparam logic [31:0] ONYUK = 32'h8844_22F1;

  initial begin
    bit [1:0]  boy;
    bit [31:0] adr;
    int        off;
    int        idx;
    int        r;
    rst = 1'b0; istek_gecerli = 1'b0; istek_yaz = 1'b0; istek_boyut = 2'b00;
    istek_isaretsiz = 1'b0; istek_adres = '0; istek_veri = '0;
    pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    fork
      monitor();
    join_none
    @(negedge clk); #1;
    sifir_cikis("reset");
    for (int i = 0; i < 128; i++) preload(i, $urandom());
    rst = 1'b1;
    #1 chk("serbest hazir", {31'b0, istek_hazir}, 32'd1);

    preload(4, ONYUK);
    issue(0, 2, 0, 32'h10, 0, 1, 0);
    preload(4, ONYUK);
    issue(0, 0, 0, 32'h13, 0, 1, 0);
    issue(0, 0, 1, 32'h10, 0, 1, 0);
    issue(0, 1, 0, 32'h12, 0, 1, 0);
    issue(0, 1, 1, 32'h12, 0, 1, 0);
    bosalt();

    preload(4, ONYUK);
    issue(1, 0, 0, 32'h11, 32'h1234_56AB, 1, 0);
    issue(0, 2, 0, 32'h10, 0, 1, 0);
    bosalt();
    chk("SB bellek[4]", mem[4], 32'h8844_ABF1);

    preload(4, ONYUK);
    issue(1, 2, 0, 32'h14, 32'hDEAD_BEEF, 1, 0);
    issue(1, 1, 0, 32'h16, 32'h0000_CAFE, 1, 0);
    bosalt();
    chk("SH bellek[5]", mem[5], 32'hCAFE_BEEF);

    preload(4, ONYUK);
    issue(0, 1, 0, 32'h11, 0, 1, 0);
    issue(1, 2, 0, 32'h12, 32'h1111_1111, 1, 0);
    issue(0, 3, 0, 32'h10, 0, 1, 0);
    issue(0, 2, 0, 32'h200, 0, 1, 0);
    bosalt();
    chk("hata sonrasi bellek[4]", mem[4], ONYUK);

    // Reset during OKU of SB, then during YAZ of SW: neither may reach memory.
    preload(4, ONYUK);
    issue(1, 0, 0, 32'h10, 32'h0000_0055, 0, 1);
    sifir_cikis("OKU_reset");
    @(negedge clk); #1;
    rst = 1'b1;
    #1 chk("OKU_reset sonrasi hazir", {31'b0, istek_hazir}, 32'd1);
    chk("OKU_reset bellek[4]", mem[4], ONYUK);
    issue(0, 2, 0, 32'h10, 0, 1, 0);
    bosalt();

    preload(5, 32'h0102_0304);
    issue(1, 2, 0, 32'h14, 32'hFFFF_FFFF, 0, 1);
    sifir_cikis("YAZ_reset");
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("YAZ_reset bellek[5]", mem[5], 32'h0102_0304);
    issue(0, 2, 0, 32'h14, 0, 1, 0);
    bosalt();

    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0)      idx = int'($urandom_range(128, 2000));
      else if (r == 1) idx = int'($urandom_range(124, 127));
      else             idx = int'($urandom_range(0, 15));
      boy = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      off = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (boy == 1) off = off & 2;
        if (boy == 2) off = 0;
      end
      adr = 32'(idx * 4 + off);
      if (r == 2) adr = $urandom();
      issue(1'($urandom()), boy, 1'($urandom()), adr, $urandom(), 1, 0);
    end
    bosalt();
    for (int i = 0; i < 16; i++) chk($sformatf("son bellek[%0d]", i), mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
